// File: rtl/ifu_prefetch.sv
`timescale 1ns/1ps
// ifu_prefetch: instruction fetch unit with a prefetch FIFO.
// Owns the fetch PC and issues one word fetch at a time over a valid/ready
// request channel. Responses of any latency are buffered and handed to
// decode over a valid/ready handshake. A redirect flushes the buffer and
// drops whichever response is still in flight.
module ifu_prefetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
  parameter int              FIFO_DEPTH = 4,
  parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en,
  input  logic [XLEN-1:0]  jump_pc,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [XLEN-1:0]  req_addr,
  input  logic             resp_valid,
  input  logic [31:0]      resp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [CNT_W-1:0] occupancy
);

  localparam int               AW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Fetch and request-tracking state
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_req_pc;
  logic             r_outstanding;
  logic             r_discard;

  // FIFO storage; pointers carry one extra wrap bit so full/empty differ
  logic [XLEN-1:0]  r_mem_pc   [FIFO_DEPTH];
  logic [31:0]      r_mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;

  logic [CNT_W-1:0] w_occ;
  logic [AW-1:0]    w_rd_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_req_fire;
  logic             w_resp_take;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_jump_tgt;

  assign w_occ      = r_wr_ptr - r_rd_ptr;
  assign w_rd_idx   = r_rd_ptr[AW-1:0];
  assign w_wr_idx   = r_wr_ptr[AW-1:0];
  assign w_jump_tgt = jump_pc & ~XLEN'(3);

  // A slot is reserved for the in-flight response by refusing to issue
  // once the FIFO is full, so a push can never overflow.
  assign req_valid   = !rst && !r_outstanding && !jump_en && (w_occ < DEPTH_C);
  assign req_addr    = r_fetch_pc;
  assign w_req_fire  = req_valid && req_ready;

  // Responses only count while a request is outstanding; a response
  // coinciding with a redirect is stale and is dropped.
  assign w_resp_take = resp_valid && r_outstanding;
  assign w_push      = w_resp_take && !r_discard && !jump_en;

  assign inst_valid  = (w_occ != '0);
  assign w_pop       = inst_valid && inst_ready;
  assign occupancy   = w_occ;

  // Head is gated so nothing stale is ever visible while the FIFO is empty
  assign inst        = inst_valid ? r_mem_data[w_rd_idx] : '0;
  assign inst_pc     = inst_valid ? r_mem_pc[w_rd_idx]   : '0;

  // Fetch PC advance, redirect, and request/response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      if (jump_en) begin
        r_fetch_pc <= w_jump_tgt;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_req_fire) begin
        r_req_pc <= r_fetch_pc;
      end
      if (w_resp_take) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end else begin
        if (w_req_fire) begin
          r_outstanding <= 1'b1;
        end
        // The single in-flight response must be swallowed when it returns
        if (jump_en && r_outstanding) begin
          r_discard <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers; a redirect empties the FIFO after any same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      end
      if (jump_en) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end
    end
  end

  // FIFO storage write; contents need no reset since the head is gated
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[w_wr_idx]   <= r_req_pc;
      r_mem_data[w_wr_idx] <= resp_data;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
`timescale 1ns/1ps
// Scoreboard bench for ifu_prefetch: directed scenarios push the expected
// {pc, word} pairs; a negedge monitor pops and compares on every decode
// handshake.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk        (clk),
    .rst        (rst),
    .jump_en    (jump_en),
    .jump_pc    (jump_pc),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .occupancy  (occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every accepted head must match the oldest expected entry
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst got_pc=%h got_inst=%h exp=none", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e[63:32]);
        chk("inst", inst, e[31:0]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; jump_en = 1'b0; jump_pc = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; inst_ready = 1'b0;
    cyc();
    smp();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    cyc();
    rst = 1'b0;
    exp_q.delete();
    smp();
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("post_rst_req_valid", 32'(req_valid), 32'd1);
    chk("post_rst_req_addr", req_addr, 32'h8000_0000);
    cyc();
  endtask

  // Issue one fetch at the expected address and answer it after lat cycles
  task automatic do_req(input logic [31:0] addr, input logic [31:0] word,
                        input int lat, input bit keep);
    int n = 0;
    req_ready = 1'b1;
    smp();
    while (!req_valid && n < 20) begin
      cyc();
      smp();
      n++;
    end
    chk("req_valid_wait", 32'(req_valid), 32'd1);
    chk("req_addr", req_addr, addr);
    if (keep) exp_q.push_back({addr, word});
    cyc();
    req_ready = 1'b0;
    repeat (lat - 1) cyc();
    resp_valid = 1'b1;
    resp_data  = word;
    cyc();
    resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: sequential fetch, 1-cycle memory, decode always ready
    do_reset();
    inst_ready = 1'b1;
    do_req(32'h8000_0000, 32'h0000_0013, 1, 1);
    do_req(32'h8000_0004, 32'h0010_0093, 1, 1);
    do_req(32'h8000_0008, 32'h0020_8113, 1, 1);
    cyc(); cyc();
    chk("s1_drained", 32'(exp_q.size()), 32'd0);
    smp();
    chk("s1_occ", 32'(occupancy), 32'd0);
    cyc();

    // 2: decode stalled, FIFO fills to depth, then drains in order
    do_reset();
    inst_ready = 1'b0;
    do_req(32'h8000_0000, 32'hA000_0001, 1, 1);
    do_req(32'h8000_0004, 32'hA000_0002, 1, 1);
    do_req(32'h8000_0008, 32'hA000_0003, 1, 1);
    smp();
    chk("s2_occ3", 32'(occupancy), 32'd3);
    chk("s2_req_valid_occ3", 32'(req_valid), 32'd1);
    cyc();
    do_req(32'h8000_000C, 32'hA000_0004, 1, 1);
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("s2_occ4", 32'(occupancy), 32'd4);
      chk("s2_req_valid_full", 32'(req_valid), 32'd0);
      cyc();
    end
    req_ready = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 10 && occupancy != 0; i++) cyc();
    smp();
    chk("s2_drained_occ", 32'(occupancy), 32'd0);
    chk("s2_drained_q", 32'(exp_q.size()), 32'd0);
    chk("s2_held_addr", req_addr, 32'h8000_0010);
    cyc();

    // 3: redirect while a 5-cycle response is in flight
    do_reset();
    inst_ready = 1'b1;
    req_ready = 1'b1;
    smp();
    chk("s3_req_addr0", req_addr, 32'h8000_0000);
    cyc();
    req_ready = 1'b0;
    cyc();
    jump_en = 1'b1;
    jump_pc = 32'h8000_0103;
    smp();
    chk("s3_no_req_in_jump", 32'(req_valid), 32'd0);
    cyc();
    jump_en = 1'b0;
    smp();
    chk("s3_occ_after_jump", 32'(occupancy), 32'd0);
    chk("s3_wait_stale", 32'(req_valid), 32'd0);
    cyc();
    cyc();
    resp_valid = 1'b1;
    resp_data  = 32'hDEAD_BEEF;
    cyc();
    resp_valid = 1'b0;
    smp();
    chk("s3_stale_dropped_occ", 32'(occupancy), 32'd0);
    chk("s3_stale_inst_valid", 32'(inst_valid), 32'd0);
    chk("s3_req_valid_after", 32'(req_valid), 32'd1);
    cyc();
    do_req(32'h8000_0100, 32'h1234_5678, 1, 1);
    cyc(); cyc();
    chk("s3_drained", 32'(exp_q.size()), 32'd0);

    // 4: redirect coinciding with a pop at occupancy 3
    do_reset();
    inst_ready = 1'b0;
    do_req(32'h8000_0000, 32'hB000_0001, 1, 1);
    do_req(32'h8000_0004, 32'hB000_0002, 1, 1);
    do_req(32'h8000_0008, 32'hB000_0003, 1, 1);
    smp();
    chk("s4_occ3", 32'(occupancy), 32'd3);
    cyc();
    inst_ready = 1'b1;
    jump_en = 1'b1;
    jump_pc = 32'h8000_0200;
    cyc();
    jump_en = 1'b0;
    chk("s4_head_consumed", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("s4_flushed_occ", 32'(occupancy), 32'd0);
      chk("s4_flushed_valid", 32'(inst_valid), 32'd0);
      cyc();
    end
    do_req(32'h8000_0200, 32'hB000_0200, 1, 1);
    cyc(); cyc();
    chk("s4_drained", 32'(exp_q.size()), 32'd0);

    // 5: spurious response while idle, reset with a request outstanding
    do_reset();
    inst_ready = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'hBAD0_BAD0;
    cyc();
    resp_valid = 1'b0;
    smp();
    chk("s5_spur_occ", 32'(occupancy), 32'd0);
    chk("s5_spur_req_valid", 32'(req_valid), 32'd1);
    chk("s5_spur_req_addr", req_addr, 32'h8000_0000);
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    smp();
    chk("s5_outstanding", 32'(req_valid), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'hCAFE_F00D;
    smp();
    chk("s5_rst_req_valid", 32'(req_valid), 32'd1);
    chk("s5_rst_req_addr", req_addr, 32'h8000_0000);
    cyc();
    resp_valid = 1'b0;
    smp();
    chk("s5_late_occ", 32'(occupancy), 32'd0);
    chk("s5_late_inst_valid", 32'(inst_valid), 32'd0);
    cyc();

    // 6: fetch PC wraps past the top of the address space
    do_reset();
    inst_ready = 1'b1;
    jump_en = 1'b1;
    jump_pc = 32'hFFFF_FFFE;
    cyc();
    jump_en = 1'b0;
    do_req(32'hFFFF_FFFC, 32'hC000_0001, 2, 1);
    do_req(32'h0000_0000, 32'hC000_0002, 1, 1);
    cyc(); cyc();
    chk("s6_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
